// File: rtl/lc3_writeback_param.sv
// LC-3 writeback stage: source select, register file write, N/Z/P status update,
// commit strobe and saturating commit counter. Optional same-cycle forwarding via WB_BYPASS_EN.
module lc3_writeback_param #(
  parameter int unsigned   DATA_W  = 16,
  parameter int unsigned   NREGS   = 8,
  parameter int unsigned   CNT_W   = 16,
  parameter logic [2:0]    PSR_RST = 3'b010,
  localparam int unsigned  AW      = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control_in,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [AW-1:0]     sr1,
  input  logic [AW-1:0]     sr2,
  input  logic [AW-1:0]     dr,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [2:0]        psr,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_dr,
  output logic [CNT_W-1:0]  wb_count
);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_PC  = 2'd2,
    SRC_NPC = 2'd3
  } wb_src_e;

  logic [DATA_W-1:0] regfile [NREGS];
  logic [DATA_W-1:0] wdata;
  logic [2:0]        psr_next;

  always_comb begin
    wdata = aluout;
    case (wb_src_e'(W_Control_in))
      SRC_ALU: wdata = aluout;
      SRC_MEM: wdata = memout;
      SRC_PC:  wdata = pcout;
      SRC_NPC: wdata = npc;
      default: wdata = aluout;
    endcase
  end

  // {N,Z,P}: exactly one bit set for any value
  always_comb begin
    psr_next = {wdata[DATA_W-1], (wdata == '0), (~wdata[DATA_W-1] && (wdata != '0))};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regfile[i] <= '0;
      psr      <= PSR_RST;
      wb_valid <= 1'b0;
      wb_dr    <= '0;
      wb_count <= '0;
    end else if (enable_writeback) begin
      regfile[dr] <= wdata;
      psr         <= psr_next;
      wb_valid    <= 1'b1;
      wb_dr       <= dr;
      if (wb_count != '1) wb_count <= wb_count + CNT_W'(1);
    end else begin
      wb_valid <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the value being committed this cycle to readers of the same register
  always_comb begin
    d1 = regfile[sr1];
    d2 = regfile[sr2];
    if (reset && enable_writeback && (sr1 == dr)) d1 = wdata;
    if (reset && enable_writeback && (sr2 == dr)) d2 = wdata;
  end
`else
  always_comb begin
    d1 = regfile[sr1];
    d2 = regfile[sr2];
  end
`endif

endmodule

// File: tb/tb_lc3_writeback_param.sv
// Self-checking bench for lc3_writeback_param (CNT_W=4 to exercise saturation);
// honours WB_BYPASS_EN when computing expected read data.
module tb_lc3_writeback_param;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned AW     = 3;
  localparam logic [2:0]  PSR_RST = 3'b010;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              enable_writeback;
  logic [1:0]        W_Control_in;
  logic [DATA_W-1:0] npc, aluout, pcout, memout;
  logic [AW-1:0]     sr1, sr2, dr;
  logic [DATA_W-1:0] d1, d2;
  logic [2:0]        psr;
  logic              wb_valid;
  logic [AW-1:0]     wb_dr;
  logic [CNT_W-1:0]  wb_count;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [DATA_W-1:0] m_regs [NREGS];
  logic [2:0]        m_psr;
  logic              m_valid;
  logic [AW-1:0]     m_dr;
  int                m_cnt;

  lc3_writeback_param #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .CNT_W  (CNT_W),
    .PSR_RST(PSR_RST)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable_writeback(enable_writeback),
    .W_Control_in    (W_Control_in),
    .npc             (npc),
    .aluout          (aluout),
    .pcout           (pcout),
    .memout          (memout),
    .sr1             (sr1),
    .sr2             (sr2),
    .dr              (dr),
    .d1              (d1),
    .d2              (d2),
    .psr             (psr),
    .wb_valid        (wb_valid),
    .wb_dr           (wb_dr),
    .wb_count        (wb_count)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] sel_w();
    logic [DATA_W-1:0] src [4];
    src[0] = aluout; src[1] = memout; src[2] = pcout; src[3] = npc;
    return src[W_Control_in];
  endfunction

  function automatic logic [2:0] psr_of(input logic [DATA_W-1:0] w);
    if (w == 0) return 3'b010;
    if ($signed(w) < 0) return 3'b100;
    return 3'b001;
  endfunction

  function automatic logic [DATA_W-1:0] exp_read(input logic [AW-1:0] a);
    if (BYP && reset && enable_writeback && a == dr) return sel_w();
    return m_regs[a];
  endfunction

  // apply the current inputs to the model, then advance one clock
  task automatic tick();
    logic [DATA_W-1:0] w;
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_psr = PSR_RST; m_valid = 1'b0; m_dr = '0; m_cnt = 0;
    end else if (enable_writeback) begin
      w = sel_w();
      m_regs[dr] = w;
      m_psr = psr_of(w);
      m_valid = 1'b1;
      m_dr = dr;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [1:0] ctl, input logic [DATA_W-1:0] v);
    enable_writeback = 1'b1; dr = a; W_Control_in = ctl;
    aluout = v; memout = v; pcout = v; npc = v;
    tick();
    enable_writeback = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable_writeback = 1'b0; W_Control_in = 2'd0;
    npc = '0; aluout = '0; pcout = '0; memout = '0; sr1 = '0; sr2 = '0; dr = '0;
    tick(); tick();
    for (int i = 0; i < NREGS; i++) begin
      sr1 = AW'(i); sr2 = AW'(NREGS - 1 - i); #1;
      checks++; if (d1 !== '0) begin errors++; $display("FAIL reset_d1 sr=%0d got=%h exp=0000", i, d1); end
      checks++; if (d2 !== '0) begin errors++; $display("FAIL reset_d2 sr=%0d got=%h exp=0000", NREGS-1-i, d2); end
    end
    checks++; if (psr !== 3'b010) begin errors++; $display("FAIL reset_psr got=%b exp=010", psr); end
    checks++; if (wb_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
    reset = 1'b1;
  endtask

  task automatic test_source_select();
    logic [DATA_W-1:0] expv [4];
    expv[0] = 16'h0011; expv[1] = 16'h0022; expv[2] = 16'h0033; expv[3] = 16'h0044;
    aluout = 16'h0011; memout = 16'h0022; pcout = 16'h0033; npc = 16'h0044;
    dr = 3'd3; sr1 = 3'd3; sr2 = 3'd0;
    for (int c = 0; c < 4; c++) begin
      enable_writeback = 1'b1; W_Control_in = 2'(c);
      tick();
      enable_writeback = 1'b0; #1;
      checks++; if (d1 !== expv[c]) begin errors++; $display("FAIL src_sel ctl=%0d got=%h exp=%h", c, d1, expv[c]); end
      checks++; if (psr !== 3'b001) begin errors++; $display("FAIL src_psr ctl=%0d got=%b exp=001", c, psr); end
      checks++; if (wb_dr !== 3'd3 || wb_valid !== 1'b1) begin errors++; $display("FAIL src_wb ctl=%0d got=%0d/%b exp=3/1", c, wb_dr, wb_valid); end
    end
  endtask

  task automatic test_psr();
    logic [DATA_W-1:0] vals [3];
    logic [2:0] exps [3];
    vals[0] = 16'h8000; vals[1] = 16'h0000; vals[2] = 16'h7FFF;
    exps[0] = 3'b100;   exps[1] = 3'b010;   exps[2] = 3'b001;
    for (int k = 0; k < 3; k++) begin
      write(3'd1, 2'd1, vals[k]);
      checks++; if (psr !== exps[k]) begin errors++; $display("FAIL psr_code v=%h got=%b exp=%b", vals[k], psr, exps[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      aluout = '0; tick();
      checks++; if (psr !== 3'b001) begin errors++; $display("FAIL psr_hold cyc=%0d got=%b exp=001", k, psr); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", k, wb_valid); end
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] pre;
    write(3'd5, 2'd0, 16'h1234);
    sr1 = 3'd5; sr2 = 3'd5; dr = 3'd5; W_Control_in = 2'd0;
    aluout = 16'hBEEF; memout = 16'h0; pcout = 16'h0; npc = 16'h0;
    enable_writeback = 1'b1; #1;
    pre = BYP ? 16'hBEEF : 16'h1234;
    checks++; if (d1 !== pre) begin errors++; $display("FAIL bypass_d1_pre got=%h exp=%h", d1, pre); end
    checks++; if (d2 !== pre) begin errors++; $display("FAIL bypass_d2_pre got=%h exp=%h", d2, pre); end
    tick();
    enable_writeback = 1'b0; #1;
    checks++; if (d1 !== 16'hBEEF) begin errors++; $display("FAIL bypass_d1_post got=%h exp=beef", d1); end
    checks++; if (d2 !== 16'hBEEF) begin errors++; $display("FAIL bypass_d2_post got=%h exp=beef", d2); end
  endtask

  task automatic test_reset_vs_write();
    write(3'd2, 2'd0, 16'h0055);
    reset = 1'b0; enable_writeback = 1'b1; dr = 3'd2; W_Control_in = 2'd0; aluout = 16'hFFFF;
    tick();
    reset = 1'b1; enable_writeback = 1'b0; sr1 = 3'd2; #1;
    checks++; if (d1 !== '0) begin errors++; $display("FAIL rvw_r2 got=%h exp=0000", d1); end
    checks++; if (psr !== PSR_RST) begin errors++; $display("FAIL rvw_psr got=%b exp=%b", psr, PSR_RST); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rvw_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_count !== '0) begin errors++; $display("FAIL rvw_count got=%0d exp=0", wb_count); end
  endtask

  task automatic test_back_to_back();
    enable_writeback = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dr = AW'($urandom_range(0, NREGS - 1));
      W_Control_in = 2'($urandom_range(0, 3));
      aluout = 16'($urandom); memout = 16'($urandom); pcout = 16'($urandom); npc = 16'($urandom);
      tick();
      checks++; if (wb_count !== CNT_W'((i + 1 > 15) ? 15 : i + 1)) begin errors++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, wb_count, (i + 1 > 15) ? 15 : i + 1); end
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, wb_valid); end
      checks++; if (wb_dr !== dr) begin errors++; $display("FAIL b2b_dr i=%0d got=%0d exp=%0d", i, wb_dr, dr); end
      checks++; if (psr !== m_psr) begin errors++; $display("FAIL b2b_psr i=%0d got=%b exp=%b", i, psr, m_psr); end
    end
    enable_writeback = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 29) != 0);
      enable_writeback = ($urandom_range(0, 3) != 0);
      W_Control_in = 2'($urandom_range(0, 3));
      aluout = 16'($urandom); memout = 16'($urandom); pcout = 16'($urandom); npc = 16'($urandom);
      if ($urandom_range(0, 7) == 0) aluout = '0;
      sr1 = AW'($urandom_range(0, NREGS - 1));
      sr2 = ($urandom_range(0, 3) == 0) ? sr1 : AW'($urandom_range(0, NREGS - 1));
      dr  = ($urandom_range(0, 2) == 0) ? sr1 : AW'($urandom_range(0, NREGS - 1));
      #1;
      checks++; if (d1 !== exp_read(sr1)) begin errors++; $display("FAIL rnd_d1 i=%0d got=%h exp=%h", i, d1, exp_read(sr1)); end
      checks++; if (d2 !== exp_read(sr2)) begin errors++; $display("FAIL rnd_d2 i=%0d got=%h exp=%h", i, d2, exp_read(sr2)); end
      tick();
      checks++; if (psr !== m_psr) begin errors++; $display("FAIL rnd_psr i=%0d got=%b exp=%b", i, psr, m_psr); end
      checks++; if (wb_valid !== m_valid) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, wb_valid, m_valid); end
      checks++; if (wb_dr !== m_dr) begin errors++; $display("FAIL rnd_dr i=%0d got=%0d exp=%0d", i, wb_dr, m_dr); end
      checks++; if (wb_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, wb_count, m_cnt); end
    end
    reset = 1'b1; enable_writeback = 1'b0;
  endtask

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_source_select();
    test_psr();
    test_bypass();
    test_reset_vs_write();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_writeback_param.md
# lc3_writeback_param

Parametrised LC-3 writeback stage: selects the result source, writes the register file and updates the processor status register (PSR: N/Z/P condition codes). It generalises the 16-bit/8-register writeback to configurable data width and register count. It adds a fourth write source, a saturating retired-write counter and a registered write-commit strobe. It sits at the end of the pipeline, fed by execute/memaccess, and supplies operand reads (d1/d2) back to decode/execute.

## Interface
- DATA_W, 16, data path width (≥4)
- NREGS, 8, register count, power of two ≥2; AW = $clog2(NREGS)
- CNT_W, 16, width of wb_count
- PSR_RST, 3'b010, PSR value after reset
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- enable_writeback  in  1  write-enable qualifier for this cycle
- W_Control_in  in  2  source select: 0 aluout, 1 memout, 2 pcout, 3 npc
- npc, aluout, pcout, memout  in  DATA_W each  candidate write data
- sr1, sr2  in  AW  read addresses
- dr  in  AW  write address
- d1, d2  out  DATA_W  read data for sr1/sr2
- psr  out  3  {N,Z,P}
- wb_valid  out  1  one-cycle pulse: write committed at the previous edge
- wb_dr  out  AW  register written at the previous edge (valid with wb_valid)
- wb_count  out  CNT_W  number of committed writes, saturating

## Operation
- wdata = mux(W_Control_in) over {aluout, memout, pcout, npc}; purely combinational.
- Commit: on a rising edge with reset=1 and enable_writeback=1:
  - regfile[dr] <= wdata
  - psr <= {wdata[DATA_W-1], wdata==0, !wdata[DATA_W-1] && wdata!=0}; exactly one bit is set.
  - wb_valid <= 1; wb_dr <= dr
  - wb_count <= wb_count+1, holds at 2^CNT_W-1 (no wrap)
- No commit (enable_writeback=0): the regfile, psr, wb_dr and wb_count hold; wb_valid <= 0.
- Reads: d1 = regfile[sr1], d2 = regfile[sr2]; combinational, no reset gating.
- sr1==sr2 is legal; both outputs show the same value.
- All address values 0..NREGS-1 are valid. There are no illegal encodings.
- Reset (reset=0 at an edge): all NREGS registers <= 0, psr <= PSR_RST, wb_valid <= 0, wb_dr <= 0, wb_count <= 0.
- Reset wins over a simultaneous enable_writeback; the write is dropped.
- There is no FSM. The state is the regfile, psr, wb_valid, wb_dr and wb_count.

## Timing
- Write latency: 1 clock. Data selected in cycle N is visible on d1/d2 from cycle N+1 (without bypass).
- psr, wb_valid, wb_dr and wb_count all change at the same edge as the regfile write.
- Back-to-back writes every cycle are supported. wb_valid stays high for consecutive commits.
- Write to the same dr on consecutive cycles: last write wins, and each write updates psr.
- Read-during-write (sr1 or sr2 == dr while enable_writeback=1): the behaviour is set by the macro in Configuration.
- Reset is sampled only at clock edges. Deasserting it mid-stream resumes normal commits on the next edge.

## Configuration
- WB_BYPASS_EN defined:
  - When enable_writeback=1 and reset=1, d1 returns wdata if sr1==dr, and d2 returns wdata if sr2==dr, in the same cycle.
  - This is a combinational forward path from the sources to d1/d2.
- WB_BYPASS_EN undefined:
  - d1/d2 always return stored register contents. A same-cycle read of dr returns the old value.
  - There is no combinational path from the source inputs to d1/d2.

## Test plan
- Reset: hold reset=0 for 2 clocks. Required: all registers read 0 on d1/d2 for every sr; psr=3'b010; wb_count=0; wb_valid=0.
- Source select: write R3 with W_Control_in=0,1,2,3, where aluout=16'h0011, memout=16'h0022, pcout=16'h0033, npc=16'h0044. Required after each edge: d1 (sr1=3) reads the selected value; psr=3'b001.
- PSR coding:
  - write 16'h8000. Required: psr=3'b100.
  - write 16'h0000. Required: psr=3'b010.
  - write 16'h7FFF. Required: psr=3'b001.
  - Hold enable=0 for 3 cycles. Required: psr unchanged.
- Bypass: sr1=sr2=dr=5, R5=16'h1234, write aluout=16'hBEEF in the same cycle.
  - With WB_BYPASS_EN: d1=d2=16'hBEEF before the edge.
  - Without WB_BYPASS_EN: d1=d2=16'h1234 before the edge, then 16'hBEEF after it.
- Reset vs write: reset=0 and enable_writeback=1 at the same edge, dr=2, aluout=16'hFFFF. Required: R2=0, psr=PSR_RST, wb_valid=0.
- Counter saturation: CNT_W=4, 20 consecutive commits. Required: wb_count reaches 15 and holds; wb_valid stays 1 throughout; wb_dr tracks each dr.
